// File: rtl/if_fetch_pkg.sv
// Shared CPU constants and types used by the instruction-fetch unit.
package if_fetch_pkg;

  localparam int XLEN         = 32;  // instruction / byte-address width
  localparam int AW           = 30;  // word-address width (pc[31:2])
  localparam int IF_DEPTH     = 4;   // default instruction-queue entries
  localparam int IF_MAX_OUTST = 2;   // default requests in flight

  // One instruction-queue entry: word address of the fetch plus the data.
  typedef struct packed {
    logic [AW-1:0]   tag;
    logic [XLEN-1:0] word;
  } iq_entry_t;

  // Word address to byte address.
  function automatic logic [XLEN-1:0] word_to_byte(input logic [AW-1:0] w);
    return {w, 2'b00};
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Small synchronous FIFO with flush. Head data is read straight from storage
// and forced to zero while empty, so the output is zero whenever no entry is
// held. Storage itself carries no reset.
module if_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          valid,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  // Pointers wrap at DEPTH even when DEPTH is not a power of two.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Qualify requests: never pop empty, never push full (unless a pop frees a slot).
  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && ((count != FULL) || do_pop);
  end

  // Data storage write, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Pointer and occupancy update; flush empties the FIFO and wins over push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= nxt(wptr);
      if (do_pop)  rptr <= nxt(rptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Head view, zero while empty.
  always_comb begin
    valid = (count != '0);
    rdata = valid ? mem[rptr] : '0;
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch unit: issues word reads to instruction memory, tracks the
// address of every granted request in an in-order tag FIFO, and collects the
// returning words into an instruction queue read by decode.
//
// Handshakes: imem_req/imem_gnt transfer a request on a cycle where both are 1
// (pc_wr marks that cycle); imem_rvalid returns one word per cycle in request
// order; inst_valid/inst_ready hand the queue head to decode on a cycle where
// both are 1. A redirect cancels everything already fetched or in flight.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int DEPTH     = IF_DEPTH,
  parameter int MAX_OUTST = IF_MAX_OUTST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   pc,
  output logic            pc_wr,
  input  logic            redirect,
  output logic            imem_req,
  output logic [AW-1:0]   imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready
);

  localparam int QCW = $clog2(DEPTH + 1);
  localparam int OCW = $clog2(MAX_OUTST + 1);

  logic [QCW-1:0] count;     // instruction-queue occupancy
  logic [OCW-1:0] outst;     // granted requests still awaiting data
  logic [OCW-1:0] discard;   // responses still to be thrown away after a redirect
  logic           tag_valid;
  logic [AW-1:0]  tag_head;
  logic           rsp;       // legal response this cycle
  logic           rsp_keep;  // response that goes into the queue
  logic           q_pop;
  iq_entry_t      q_wdata;
  iq_entry_t      q_head;

  // Request only when a queue slot is reserved for every word in flight plus this one.
  always_comb begin
    imem_req  = rst && !redirect && (int'(outst) < MAX_OUTST)
                && ((int'(count) + int'(outst)) < DEPTH);
    pc_wr     = imem_req && imem_gnt;
    imem_addr = pc;
    rsp       = imem_rvalid && tag_valid;
    rsp_keep  = rsp && (discard == '0) && !redirect;
    q_pop     = inst_valid && inst_ready && !redirect;
    q_wdata   = '{tag: tag_head, word: imem_rdata};
    inst      = q_head.word;
    inst_pc   = word_to_byte(q_head.tag);
  end

  // Address of every granted request, popped as its response returns.
  if_fifo #(.W(AW), .DEPTH(MAX_OUTST)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (1'b0),
    .push  (pc_wr),
    .wdata (pc),
    .pop   (rsp),
    .rdata (tag_head),
    .valid (tag_valid),
    .count (outst)
  );

  // Fetched instructions waiting for decode; emptied by a redirect.
  if_fifo #(.W($bits(iq_entry_t)), .DEPTH(DEPTH)) u_inst_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (rsp_keep),
    .wdata (q_wdata),
    .pop   (q_pop),
    .rdata (q_head),
    .valid (inst_valid),
    .count (count)
  );

  // Discard counter: on redirect, every response still owed after this cycle is stale.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      discard <= '0;
    end else if (redirect) begin
      discard <= outst - OCW'(rsp);
    end else if (rsp && (discard != '0)) begin
      discard <= discard - OCW'(1);
    end
  end

  // A response with nothing outstanding means the memory side lost track.
  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst)
                                       !(imem_rvalid && (outst == '0)));

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: a table of per-cycle vectors for the basic stream, then
// hand-written sequences driven through a simple in-order memory model with a
// configurable latency and a scoreboard of expected fetch addresses.
module tb_if_fetch;
  import if_fetch_pkg::*;

  logic            clk;
  logic            rst;
  logic [AW-1:0]   pc;
  logic            pc_wr;
  logic            redirect;
  logic            imem_req;
  logic [AW-1:0]   imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            inst_valid;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_ready;

  if_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .pc_wr       (pc_wr),
    .redirect    (redirect),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  int            lat   = 1;
  int            pops  = 0;
  logic [AW-1:0] bpc;               // bench copy of the upstream PC register
  logic [AW-1:0] mq_addr[$];        // memory model: granted addresses
  int            mq_due[$];         // memory model: cycle each response is due
  logic [AW-1:0] exp_q[$];          // scoreboard: addresses decode must see, in order
  logic          got_first;
  logic [31:0]   first_ipc;

  function automatic logic [31:0] data_of(input logic [AW-1:0] a);
    return {2'b10, a};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_in(input logic g, input logic rdy, input logic rd);
    imem_gnt    = g;
    inst_ready  = rdy;
    redirect    = rd;
    pc          = bpc;
    imem_rvalid = (mq_addr.size() > 0) && (mq_due[0] <= cyc);
    imem_rdata  = imem_rvalid ? data_of(mq_addr[0]) : 32'h0;
    #1;
  endtask

  task automatic finish_cycle(input logic rd, input logic [AW-1:0] new_pc);
    logic [AW-1:0] e;
    if (inst_valid && inst_ready && !rd) begin
      pops++;
      if (!got_first) begin
        got_first = 1'b1;
        first_ipc = inst_pc;
      end
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_pop", inst_pc, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("sb_inst_pc", inst_pc, {e, 2'b00});
        chk("sb_inst", inst, data_of(e));
      end
    end
    if (rd) begin
      exp_q.delete();
      got_first = 1'b0;
    end
    if (imem_rvalid) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (pc_wr) begin
      mq_addr.push_back(bpc);
      mq_due.push_back(cyc + lat);
      exp_q.push_back(bpc);
      bpc = bpc + 1'b1;
    end
    if (rd) bpc = new_pc;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step(input logic g, input logic rdy);
    drive_in(g, rdy, 1'b0);
    finish_cycle(1'b0, '0);
  endtask

  // Asynchronous reset: outputs must clear at once, before any clock edge.
  task automatic do_reset(input logic [AW-1:0] start_pc);
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b0;
    redirect    = 1'b0;
    rst         = 1'b0;
    mq_addr.delete();
    mq_due.delete();
    exp_q.delete();
    #1;
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_pc_wr", pc_wr, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_inst", inst, 0);
    imem_gnt   = 1'b0;
    inst_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b1;
    cyc       = 0;
    pops      = 0;
    got_first = 1'b0;
    bpc       = start_pc;
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic          gnt;
    logic          rv;
    logic          rdy;
    logic [AW-1:0] pcv;
    logic [AW-1:0] rv_addr;
    logic          e_req;
    logic          e_pcwr;
    logic          e_valid;
    logic [31:0]   e_ipc;
    logic [AW-1:0] e_addr;
  } vec_t;

  function automatic vec_t mk(input logic g, input logic rv, input logic rdy,
                              input logic [AW-1:0] pcv, input logic [AW-1:0] rva,
                              input logic er, input logic ew, input logic ev,
                              input logic [31:0] eipc, input logic [AW-1:0] ea);
    vec_t v;
    v.gnt = g;  v.rv = rv;  v.rdy = rdy;  v.pcv = pcv;  v.rv_addr = rva;
    v.e_req = er;  v.e_pcwr = ew;  v.e_valid = ev;  v.e_ipc = eipc;  v.e_addr = ea;
    return v;
  endfunction

  vec_t tbl[8];

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1;  pc = '0;  redirect = 1'b0;  imem_gnt = 1'b0;
    imem_rvalid = 1'b0;  imem_rdata = '0;  inst_ready = 1'b0;
    bpc = '0;  got_first = 1'b0;  first_ipc = '0;
    #2;

    // Streaming from 0x3000, gnt=1, 1-cycle memory, decode always ready.
    tbl[0] = mk(1, 0, 1, 30'hC00, 30'h000, 1, 1, 0, 32'h0,         30'h000);
    tbl[1] = mk(1, 1, 1, 30'hC01, 30'hC00, 1, 1, 0, 32'h0,         30'h000);
    tbl[2] = mk(1, 1, 1, 30'hC02, 30'hC01, 1, 1, 1, 32'h0000_3000, 30'hC00);
    tbl[3] = mk(1, 1, 1, 30'hC03, 30'hC02, 1, 1, 1, 32'h0000_3004, 30'hC01);
    tbl[4] = mk(1, 1, 1, 30'hC04, 30'hC03, 1, 1, 1, 32'h0000_3008, 30'hC02);
    tbl[5] = mk(0, 1, 1, 30'hC05, 30'hC04, 1, 0, 1, 32'h0000_300C, 30'hC03);
    tbl[6] = mk(0, 0, 1, 30'hC05, 30'h000, 1, 0, 1, 32'h0000_3010, 30'hC04);
    tbl[7] = mk(0, 0, 1, 30'hC05, 30'h000, 1, 0, 0, 32'h0,         30'h000);

    do_reset(30'hC00);
    for (int i = 0; i < 8; i++) begin
      imem_gnt    = tbl[i].gnt;
      imem_rvalid = tbl[i].rv;
      imem_rdata  = tbl[i].rv ? data_of(tbl[i].rv_addr) : 32'h0;
      inst_ready  = tbl[i].rdy;
      pc          = tbl[i].pcv;
      redirect    = 1'b0;
      #1;
      chk($sformatf("tbl%0d_imem_req", i), imem_req, tbl[i].e_req);
      chk($sformatf("tbl%0d_pc_wr", i), pc_wr, tbl[i].e_pcwr);
      chk($sformatf("tbl%0d_imem_addr", i), imem_addr, tbl[i].pcv);
      chk($sformatf("tbl%0d_inst_valid", i), inst_valid, tbl[i].e_valid);
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl%0d_inst_pc", i), inst_pc, tbl[i].e_ipc);
        chk($sformatf("tbl%0d_inst", i), inst, data_of(tbl[i].e_addr));
      end
      @(posedge clk);
      #1;
    end
    imem_rvalid = 1'b0;

    // Decode stalled: queue fills to 4 entries, requests stop, nothing is lost.
    do_reset(30'hC00);
    lat = 1;
    repeat (4) step(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive_in(1'b1, 1'b0, 1'b0);
      chk("full_imem_req", imem_req, 0);
      chk("full_pc_wr", pc_wr, 0);
      chk("full_inst_valid", inst_valid, 1);
      chk("full_head_pc", inst_pc, 32'h0000_3000);
      finish_cycle(1'b0, '0);
    end
    repeat (6) step(1'b0, 1'b1);
    chk("full_pop_count", pops, 4);
    chk("full_sb_left", exp_q.size(), 0);

    // Redirect with two requests in flight and no response that cycle.
    do_reset(30'hC00);
    lat = 3;
    repeat (2) step(1'b1, 1'b1);
    drive_in(1'b1, 1'b1, 1'b1);
    chk("redir2_imem_req", imem_req, 0);
    chk("redir2_pc_wr", pc_wr, 0);
    finish_cycle(1'b1, 30'hC40);
    drive_in(1'b1, 1'b1, 1'b0);
    chk("redir2_after_valid", inst_valid, 0);
    finish_cycle(1'b0, '0);
    repeat (12) step(1'b1, 1'b1);
    repeat (8) step(1'b0, 1'b1);
    chk("redir2_got_first", got_first, 1);
    chk("redir2_first_pc", first_ipc, 32'h0000_3100);
    chk("redir2_sb_left", exp_q.size(), 0);

    // Redirect in the same cycle as a response with two in flight.
    do_reset(30'hC00);
    lat = 2;
    repeat (2) step(1'b1, 1'b1);
    drive_in(1'b1, 1'b1, 1'b1);
    chk("redir_rv_imem_req", imem_req, 0);
    chk("redir_rv_rvalid_present", imem_rvalid, 1);
    finish_cycle(1'b1, 30'hC80);
    repeat (10) step(1'b1, 1'b1);
    repeat (8) step(1'b0, 1'b1);
    chk("redir_rv_got_first", got_first, 1);
    chk("redir_rv_first_pc", first_ipc, 32'h0000_3200);
    chk("redir_rv_sb_left", exp_q.size(), 0);

    // Memory withholds grant: request stays up, PC never advances.
    do_reset(30'hC00);
    lat = 1;
    for (int i = 0; i < 5; i++) begin
      drive_in(1'b0, 1'b1, 1'b0);
      chk("nognt_imem_req", imem_req, 1);
      chk("nognt_pc_wr", pc_wr, 0);
      chk("nognt_imem_addr", imem_addr, 30'hC00);
      finish_cycle(1'b0, '0);
    end
    repeat (3) step(1'b1, 1'b1);
    repeat (5) step(1'b0, 1'b1);
    chk("nognt_pop_count", pops, 3);
    chk("nognt_sb_left", exp_q.size(), 0);

    // Reset mid-operation with 3 queued entries and one request in flight.
    do_reset(30'hC00);
    lat = 1;
    repeat (4) step(1'b1, 1'b0);
    chk("midrst_pre_valid", inst_valid, 1);
    chk("midrst_pre_head", inst_pc, 32'h0000_3000);
    do_reset(30'hC00);
    drive_in(1'b0, 1'b0, 1'b0);
    chk("midrst_post_imem_req", imem_req, 1);
    chk("midrst_post_valid", inst_valid, 0);
    finish_cycle(1'b0, '0);
    drive_in(1'b0, 1'b0, 1'b0);
    chk("midrst_post_valid2", inst_valid, 0);
    finish_cycle(1'b0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter DEPTH, default 4, is the instruction-queue entry count (power of two, at least 2).
REQ-002 Parameter MAX_OUTST, default 2, is the maximum number of instruction-memory requests in flight.
REQ-003 clk  in  1  system clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 pc  in  30  current fetch word address [31:2], from the PC register.
REQ-006 pc_wr  out  1  PC advance enable; equals imem_req AND imem_gnt.
REQ-007 redirect  in  1  branch/jump/exception flush; the new PC is loaded upstream on the same edge.
REQ-008 imem_req  out  1  instruction-memory read request.
REQ-009 imem_addr  out  30  request word address; equals pc.
REQ-010 imem_gnt  in  1  memory accepts the request this cycle.
REQ-011 imem_rvalid  in  1  read data valid; responses return in request order, at least 1 cycle after grant.
REQ-012 imem_rdata  in  32  instruction word.
REQ-013 inst_valid  out  1  queue head is valid.
REQ-014 inst  out  32  queue-head instruction.
REQ-015 inst_pc  out  32  queue-head byte address, i.e. {tag, 2'b00}.
REQ-016 inst_ready  in  1  decode consumes the head when inst_valid is 1.

Function
REQ-017 imem_req SHALL be 1 iff redirect=0, outst<MAX_OUTST and (count+outst)<DEPTH, where count is the number of queue entries and outst is the number of granted requests awaiting data.
REQ-018 imem_req SHALL depend only on registered state and redirect; it does not depend on imem_gnt.
REQ-019 On each grant, the granted pc SHALL be pushed into a MAX_OUTST-entry in-order tag FIFO.
REQ-020 On each imem_rvalid, the oldest tag SHALL be popped; if the discard counter is 0, {tag, rdata} SHALL be written into the queue.
REQ-021 A response that arrives while the discard counter is nonzero SHALL be dropped, and the discard counter decremented.
REQ-022 Queue write latency: data written at edge N SHALL be visible on inst/inst_valid after edge N; there is no combinational rvalid-to-inst_valid path.
REQ-023 A pop (inst_valid AND inst_ready) and a push in the same cycle SHALL both take effect; count is unchanged.
REQ-024 Overflow SHALL be impossible by the reservation in REQ-017; imem_rvalid with outst=0 is illegal, is asserted against, and is ignored.
REQ-025 On redirect, the following SHALL happen on the same edge:
- count becomes 0 and inst_valid is 0 in the next cycle;
- any pop is void;
- the discard counter is loaded with outst minus (imem_rvalid ? 1 : 0);
- a response arriving in the redirect cycle is dropped.
REQ-026 Grant and redirect in the same cycle SHALL be impossible, because redirect gates imem_req.
REQ-027 A redirect while the discard counter is already nonzero SHALL reload it per REQ-025; the counter never exceeds MAX_OUTST.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH; count and outst are wide enough for DEPTH and MAX_OUTST respectively.
REQ-029 Steady state with gnt=1 and 1-cycle rvalid SHALL sustain one instruction per cycle.

Reset
REQ-030 While rst=0, all of the following SHALL hold asynchronously:
- count, outst, discard counter and pointers are 0;
- inst_valid, imem_req and pc_wr are 0;
- inst and inst_pc are 0.
REQ-031 Queue data storage SHALL need no reset.
REQ-032 Reset mid-operation SHALL abandon in-flight requests; the memory side is reset by the same rst.

Structure
REQ-033 DEPTH, MAX_OUTST defaults and the instruction/address width constants SHALL live in the shared CPU package.
REQ-034 The design SHALL use one sub-module, if_fifo: a parameterised synchronous FIFO with flush, instantiated twice (tag FIFO and instruction queue).

Verification
REQ-035 Reset release, pc=0x3000>>2, gnt=1, 1-cycle rvalid, inst_ready=1 -> inst_pc sequence 0x3000, 0x3004, 0x3008, one per cycle after a 2-cycle fill.
REQ-036 inst_ready=0 with gnt=1 -> exactly 4 entries held; imem_req drops once count+outst=4; no data lost after ready returns.
REQ-037 2 requests in flight, then redirect with pc=0x3100>>2 -> both stale responses dropped; the first inst_pc after redirect is 0x3100.
REQ-038 redirect in the same cycle as rvalid with outst=2 -> discard counter 1; the next response is dropped and the one after is accepted.
REQ-039 gnt held 0 for 5 cycles -> imem_req stays 1 and pc_wr stays 0; the PC does not advance.
REQ-040 rst asserted low with 3 queued entries and outst=1 -> inst_valid=0 immediately; a late rvalid after release is flagged by the assertion and ignored.
